fifo_rd_ctrl: RTL and testbench

// Read-domain controller of the async FIFO; sits between the dual-port memory and the consumer.

---
 rtl/fifo_rd_ctrl.sv | 79 +++++++
 tb/tb_fifo_rd_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: write-pointer synchroniser, read pointer,
// empty / almost-empty flags, and a one-entry valid/ready output register.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray,
  input  logic [DATA_WIDTH-1:0] r_data_mem,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_inc,
  output logic                  r_empty,
  output logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic [ADDR_WIDTH:0]   r_count,
  output logic                  r_aempty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] wq_gray, wq_bin;
  logic [PW-1:0] r_bin, r_bin_next, r_gray_next;

  // Only the first synchroniser flop ever sees the asynchronous write pointer.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= w_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    wq_bin = '0;
    for (int i = 0; i < PW; i++) wq_bin[i] = ^(wq_gray >> i);
  end

  assign r_inc       = !r_empty && (!out_valid || out_ready);
  assign r_bin_next  = r_bin + {{(PW-1){1'b0}}, r_inc};
  assign r_gray_next = (r_bin_next >> 1) ^ r_bin_next;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin      <= '0;
      r_ptr_gray <= '0;
      r_empty    <= 1'b1;
    end else begin
      r_bin      <= r_bin_next;
      r_ptr_gray <= r_gray_next;
      r_empty    <= (r_gray_next == wq_gray);
    end
  end

  // A pop refills the output register even while its current word is being accepted.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (r_inc) begin
      out_valid <= 1'b1;
      out_data  <= r_data_mem;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign r_addr   = r_bin[ADDR_WIDTH-1:0];
  assign r_count  = wq_bin - r_bin;
  assign r_aempty = (r_count <= PW'(AEMPTY_THRESH));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: stimulus pushes written words into a scoreboard,
// a negedge monitor pops and compares every accepted output word.
module tb_fifo_rd_ctrl;
  localparam int DW = 8, AW = 4, PW = AW + 1;

  logic          r_clk = 1'b0, r_rst_n = 1'b0;
  logic [PW-1:0] w_ptr_gray = '0;
  logic [DW-1:0] r_data_mem;
  logic [AW-1:0] r_addr;
  logic          r_inc, r_empty, r_aempty, out_valid, out_ready = 1'b0;
  logic [PW-1:0] r_ptr_gray, r_count;
  logic [DW-1:0] out_data;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] sb [$];
  logic [PW-1:0] wbin = '0;
  logic [PW-1:0] prev_gray = '0;
  logic [AW-1:0] prev_addr = '0;
  int            wrap_cnt = 0;
  int            checks = 0, passed = 0;
  logic [DW-1:0] exp_w;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2), .AEMPTY_THRESH(2)) dut (
    .r_clk(r_clk), .r_rst_n(r_rst_n), .w_ptr_gray(w_ptr_gray), .r_data_mem(r_data_mem),
    .r_addr(r_addr), .r_inc(r_inc), .r_empty(r_empty), .r_ptr_gray(r_ptr_gray),
    .r_count(r_count), .r_aempty(r_aempty), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  always #5 r_clk = ~r_clk;
  assign r_data_mem = mem[r_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic write_word(input logic [DW-1:0] d);
    mem[wbin[AW-1:0]] = d;
    sb.push_back(d);
    wbin = wbin + 1'b1;
    w_ptr_gray = gray(wbin);
  endtask

  task automatic tick();
    @(posedge r_clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) tick();
    tick();
    chk(nm, sb.size(), 0);
  endtask

  task automatic do_reset();
    r_rst_n = 1'b0; wbin = '0; w_ptr_gray = '0; out_ready = 1'b0; sb.delete();
    tick(); tick();
    r_rst_n = 1'b1;
  endtask

  // Monitor: every handshake consumes one scoreboard entry; pointer steps must be single-bit.
  always @(negedge r_clk) begin
    if (!r_rst_n) begin
      prev_gray = '0; prev_addr = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
        else begin
          exp_w = sb.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, exp_w});
        end
      end
      if (r_ptr_gray != prev_gray) chk("gray_step", $countones(r_ptr_gray ^ prev_gray), 1);
      if (prev_addr == 4'd15 && r_addr == 4'd0) wrap_cnt++;
      prev_gray = r_ptr_gray; prev_addr = r_addr;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      w_ptr_gray = PW'($urandom); out_ready = 1'($urandom); tick();
    end
    chk("rst_empty", r_empty, 1); chk("rst_valid", out_valid, 0);
    chk("rst_addr", r_addr, 0);   chk("rst_gray", r_ptr_gray, 0);
    chk("rst_count", r_count, 0); chk("rst_aempty", r_aempty, 1);
    chk("rst_inc", r_inc, 0);
    w_ptr_gray = '0; out_ready = 1'b0; tick();
    r_rst_n = 1'b1; tick();

    // 2: single word, latency 4 edges
    out_ready = 1'b1;
    write_word(8'hA5);
    tick(); tick(); tick();
    chk("lat_valid_e3", out_valid, 0);
    tick();
    chk("lat_valid_e4", out_valid, 1);
    chk("lat_data_e4", out_data, 8'hA5);
    tick(); tick();
    chk("single_addr", r_addr, 1); chk("single_gray", r_ptr_gray, 5'b00001);
    chk("single_empty", r_empty, 1);

    // 3: backpressure then burst
    out_ready = 1'b0;
    write_word(8'h11); tick();
    write_word(8'h22); tick();
    write_word(8'h33);
    repeat (6) tick();
    chk("bp_valid", out_valid, 1); chk("bp_data", out_data, 8'h11);
    chk("bp_inc", r_inc, 0);       chk("bp_count", r_count, 2);
    out_ready = 1'b1;
    tick(); chk("burst1", out_data, 8'h22); chk("burst1_v", out_valid, 1);
    tick(); chk("burst2", out_data, 8'h33); chk("burst2_v", out_valid, 1);
    tick(); chk("burst_end_v", out_valid, 0);
    wait_drain("bp_drain");

    // 4: wrap, 40 words from r_bin=0
    do_reset();
    wrap_cnt = 0;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        write_word(DW'(8'h40 + b * 10 + i)); tick();
      end
      wait_drain("wrap_drain");
    end
    chk("wrap_addr", r_addr, 8); chk("wrap_gray", r_ptr_gray, 5'b01100);
    chk("wrap_cnt", wrap_cnt, 2);

    // 5: full memory
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = DW'(8'hC0 + i);
    for (int i = 0; i < 16; i++) sb.push_back(DW'(8'hC0 + i));
    wbin = 5'd16; w_ptr_gray = 5'b11000;
    tick(); tick();
    chk("full_count", r_count, 16); chk("full_aempty", r_aempty, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && r_count != 5'd2; i++) tick();
    chk("drain_count", r_count, 2); chk("drain_aempty", r_aempty, 1);
    wait_drain("full_drain");

    // 6: reset mid-operation
    out_ready = 1'b0;
    write_word(8'h5A); write_word(8'h6B);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("mid_valid_pre", out_valid, 1);
    #1 r_rst_n = 1'b0;
    #1;
    chk("mid_valid_async", out_valid, 0); chk("mid_empty", r_empty, 1);
    chk("mid_addr", r_addr, 0);           chk("mid_count", r_count, 0);
    sb.delete(); wbin = '0; w_ptr_gray = '0;
    tick(); tick();
    r_rst_n = 1'b1; tick();
    chk("post_valid", out_valid, 0); chk("post_gray", r_ptr_gray, 0);
    chk("post_aempty", r_aempty, 1);
    out_ready = 1'b1;
    write_word(8'h3C); tick(); write_word(8'h4D);
    wait_drain("restart_drain");
    chk("restart_addr", r_addr, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
